// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // Stall vector bit positions: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]reserved
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    localparam logic MC_KIND_MULT = 1'b0;
    localparam logic MC_KIND_DIV  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/multi-cycle request inputs and stall/flush/sequencing outputs of the controller.
// Latency: n/a (wiring only).
// Backpressure: n/a; stall_o is the pipeline-wide hold signal carried here.
interface pipe_ctrl_if #(
    parameter int CNT_W = 6
);
    logic             stallreq_id;
    logic             ex_mc_req;
    logic             ex_mc_kind;
    logic             ex_div_zero;
    logic             flush_req;
    logic [5:0]       stall_o;
    logic             flush_o;
    logic             ex_mc_busy;
    logic [CNT_W-1:0] ex_mc_step;
    logic             ex_mc_done;
    logic [31:0]      stall_cnt_o;

    // Pipeline side: raises hazards/requests, consumes stall/flush/sequencing
    modport master (
        output stallreq_id, ex_mc_req, ex_mc_kind, ex_div_zero, flush_req,
        input  stall_o, flush_o, ex_mc_busy, ex_mc_step, ex_mc_done, stall_cnt_o
    );

    // Controller side
    modport slave (
        input  stallreq_id, ex_mc_req, ex_mc_kind, ex_div_zero, flush_req,
        output stall_o, flush_o, ex_mc_busy, ex_mc_step, ex_mc_done, stall_cnt_o
    );
endinterface

// File: rtl/pipe_stall_counter.sv
// 32-bit saturating event counter with enable and synchronous clear to a preset.
// Latency: count visible one cycle after the enabled cycle.
// Backpressure: none; holds at all-ones once reached.
module pipe_stall_counter #(
    parameter logic [31:0] CLR_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        i_clr,
    input  logic        i_en,
    output logic [31:0] o_cnt
);
    logic [31:0] r_cnt;

    // Count enabled cycles, stop at the top value instead of wrapping
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= CLR_VAL;
        end else if (i_en && (r_cnt != 32'hFFFF_FFFF)) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush generation and multi-cycle EX op sequencing (MULT/MADD/DIV).
// Latency: stall_o/flush_o combinational from inputs; a multi-cycle op occupies EX for N cycles.
// Backpressure: stall_o holds PC and upstream pipeline registers; flush overrides all stalls.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          MULT_CYCLES    = 4,
    parameter int          DIV_CYCLES     = 34,
    parameter int          CNT_W          = 6,
    parameter logic [31:0] STALL_CNT_INIT = 32'h0
) (
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.slave bus
);
    // Step value at which the op finishes; the DONE cycle is that step.
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_ONE  = CNT_W'(1);

    mc_state_e        r_state;
    logic [CNT_W-1:0] r_step;
    logic             r_kind;

    mc_state_e        w_state_nxt;
    logic [CNT_W-1:0] w_step_nxt;
    logic             w_kind_nxt;
    logic [CNT_W-1:0] w_req_last;
    logic [CNT_W-1:0] w_busy_last;
    logic [CNT_W-1:0] w_step_inc;

    logic [5:0]       w_stall;
    logic             w_flush;
    logic             w_busy;
    logic [CNT_W-1:0] w_step_out;
    logic             w_done;
    logic [31:0]      w_cnt;

    assign w_req_last  = (bus.ex_mc_kind == MC_KIND_DIV) ? DIV_LAST : MULT_LAST;
    assign w_busy_last = (r_kind == MC_KIND_DIV) ? DIV_LAST : MULT_LAST;
    assign w_step_inc  = r_step + STEP_ONE;

    // State register: FSM state, step counter and the kind latched at op entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_kind  <= MC_KIND_MULT;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_kind  <= w_kind_nxt;
        end
    end

    // Next-state logic; flush aborts any in-flight op. The IDLE request cycle is
    // step 0, so BUSY walks steps 1..N-2 and the DONE cycle is step N-1.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_kind_nxt  = r_kind;
        if (bus.flush_req) begin
            w_state_nxt = ST_IDLE;
            w_step_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.ex_mc_req) begin
                        w_kind_nxt = bus.ex_mc_kind;
                        if (((bus.ex_mc_kind == MC_KIND_DIV) && bus.ex_div_zero)
                            || (w_req_last == STEP_ONE)) begin
                            w_state_nxt = ST_DONE;
                            w_step_nxt  = '0;
                        end else begin
                            w_state_nxt = ST_BUSY;
                            w_step_nxt  = STEP_ONE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_step_inc == w_busy_last) begin
                        w_state_nxt = ST_DONE;
                        w_step_nxt  = '0;
                    end else begin
                        w_step_nxt  = w_step_inc;
                    end
                end
                ST_DONE: begin
                    // A request seen here is the finishing instruction's own
                    w_state_nxt = ST_IDLE;
                    w_step_nxt  = '0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_step_nxt  = '0;
                end
            endcase
        end
    end

    // Output logic: flush > EX multi-cycle stall > ID load-use stall, all quiet in reset
    always_comb begin
        w_stall    = STALL_NONE;
        w_flush    = 1'b0;
        w_busy     = 1'b0;
        w_step_out = '0;
        w_done     = 1'b0;
        if (!rst) begin
            w_busy = (r_state == ST_BUSY);
            if (r_state == ST_BUSY) begin
                w_step_out = r_step;
            end
            if (bus.flush_req) begin
                w_flush = 1'b1;
            end else begin
                case (r_state)
                    ST_BUSY: w_stall = STALL_EX;
                    ST_IDLE: begin
                        if (bus.ex_mc_req) begin
                            w_stall = STALL_EX;
                        end else if (bus.stallreq_id) begin
                            w_stall = STALL_ID;
                        end
                    end
                    ST_DONE: begin
                        w_done = 1'b1;
                        if (bus.stallreq_id) begin
                            w_stall = STALL_ID;
                        end
                    end
                    default: w_stall = STALL_NONE;
                endcase
            end
        end
    end

    pipe_stall_counter #(
        .CLR_VAL (STALL_CNT_INIT)
    ) u_stall_cnt (
        .clk   (clk),
        .i_clr (rst),
        .i_en  (w_stall != STALL_NONE),
        .o_cnt (w_cnt)
    );

    assign bus.stall_o     = w_stall;
    assign bus.flush_o     = w_flush;
    assign bus.ex_mc_busy  = w_busy;
    assign bus.ex_mc_step  = w_step_out;
    assign bus.ex_mc_done  = w_done;
    assign bus.stall_cnt_o = w_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: cycle-by-cycle vector table plus multi-cycle sequences.
// Latency: inputs driven at negedge, outputs sampled 1ns later, state advances on posedge.
// Backpressure: n/a.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk;
    logic rst;

    pipe_ctrl_if #(.CNT_W(6)) bus ();
    pipe_ctrl_if #(.CNT_W(6)) bus2 ();

    pipe_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(34), .CNT_W(6), .STALL_CNT_INIT(32'h0))
        dut (.clk(clk), .rst(rst), .bus(bus));

    // Second instance with counter preset near the top, for saturation
    pipe_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(34), .CNT_W(6), .STALL_CNT_INIT(32'hFFFF_FFFE))
        dut_sat (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, sid, req, kind, dz, fl;
        logic [5:0]  stall;
        logic        flush, busy;
        logic [5:0]  step;
        logic        done;
        logic [31:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic q, input logic k,
                                input logic z, input logic f, input logic [5:0] st,
                                input logic fo, input logic b, input logic [5:0] sp,
                                input logic d, input logic [31:0] c);
        vec_t v;
        v.rst = r; v.sid = s; v.req = q; v.kind = k; v.dz = z; v.fl = f;
        v.stall = st; v.flush = fo; v.busy = b; v.step = sp; v.done = d; v.cnt = c;
        return v;
    endfunction

    task automatic drive(input logic s, input logic q, input logic k, input logic z, input logic f);
        bus.stallreq_id = s;
        bus.ex_mc_req   = q;
        bus.ex_mc_kind  = k;
        bus.ex_div_zero = z;
        bus.flush_req   = f;
    endtask

    vec_t tv[24];

    initial begin
        logic [31:0] cnt0;
        int          done_at;

        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        bus2.stallreq_id = 0; bus2.ex_mc_req = 0; bus2.ex_mc_kind = 0;
        bus2.ex_div_zero = 0; bus2.flush_req = 0;

        //          rst sid req knd dz  fl  stall       fl  bsy step done cnt
        tv[0]  = mk(1,  1,  1,  0,  0,  0,  STALL_NONE, 0,  0,  0,   0,   0);
        tv[1]  = mk(1,  0,  0,  0,  0,  1,  STALL_NONE, 0,  0,  0,   0,   0);
        tv[2]  = mk(0,  0,  0,  0,  0,  0,  STALL_NONE, 0,  0,  0,   0,   0);
        tv[3]  = mk(0,  1,  0,  0,  0,  0,  STALL_ID,   0,  0,  0,   0,   0);
        tv[4]  = mk(0,  0,  0,  0,  0,  0,  STALL_NONE, 0,  0,  0,   0,   1);
        tv[5]  = mk(0,  0,  1,  0,  0,  0,  STALL_EX,   0,  0,  0,   0,   1);
        tv[6]  = mk(0,  0,  1,  0,  0,  0,  STALL_EX,   0,  1,  1,   0,   2);
        tv[7]  = mk(0,  0,  1,  0,  0,  0,  STALL_EX,   0,  1,  2,   0,   3);
        tv[8]  = mk(0,  0,  1,  0,  0,  0,  STALL_NONE, 0,  0,  0,   1,   4);
        tv[9]  = mk(0,  0,  0,  0,  0,  0,  STALL_NONE, 0,  0,  0,   0,   4);
        tv[10] = mk(0,  1,  1,  0,  0,  0,  STALL_EX,   0,  0,  0,   0,   4);
        tv[11] = mk(0,  0,  1,  0,  0,  0,  STALL_EX,   0,  1,  1,   0,   5);
        tv[12] = mk(0,  0,  1,  0,  0,  0,  STALL_EX,   0,  1,  2,   0,   6);
        tv[13] = mk(0,  1,  1,  0,  0,  0,  STALL_ID,   0,  0,  0,   1,   7);
        tv[14] = mk(0,  0,  1,  0,  0,  0,  STALL_EX,   0,  0,  0,   0,   8);
        tv[15] = mk(0,  0,  0,  0,  0,  0,  STALL_EX,   0,  1,  1,   0,   9);
        tv[16] = mk(0,  0,  0,  0,  0,  0,  STALL_EX,   0,  1,  2,   0,   10);
        tv[17] = mk(0,  0,  0,  0,  0,  0,  STALL_NONE, 0,  0,  0,   1,   11);
        tv[18] = mk(0,  0,  0,  0,  0,  0,  STALL_NONE, 0,  0,  0,   0,   11);
        tv[19] = mk(0,  0,  1,  1,  1,  0,  STALL_EX,   0,  0,  0,   0,   11);
        tv[20] = mk(0,  0,  1,  1,  1,  0,  STALL_NONE, 0,  0,  0,   1,   12);
        tv[21] = mk(0,  0,  0,  0,  0,  0,  STALL_NONE, 0,  0,  0,   0,   12);
        tv[22] = mk(0,  1,  1,  0,  0,  1,  STALL_NONE, 1,  0,  0,   0,   12);
        tv[23] = mk(0,  0,  0,  0,  0,  0,  STALL_NONE, 0,  0,  0,   0,   12);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            rst = tv[i].rst;
            drive(tv[i].sid, tv[i].req, tv[i].kind, tv[i].dz, tv[i].fl);
            #1;
            chk($sformatf("v%0d.stall", i), 32'(bus.stall_o),     32'(tv[i].stall));
            chk($sformatf("v%0d.flush", i), 32'(bus.flush_o),     32'(tv[i].flush));
            chk($sformatf("v%0d.busy",  i), 32'(bus.ex_mc_busy),  32'(tv[i].busy));
            chk($sformatf("v%0d.step",  i), 32'(bus.ex_mc_step),  32'(tv[i].step));
            chk($sformatf("v%0d.done",  i), 32'(bus.ex_mc_done),  32'(tv[i].done));
            chk($sformatf("v%0d.cnt",   i), bus.stall_cnt_o,      tv[i].cnt);
        end

        // Full DIV: 33 stall cycles with steps 0..32, done on the 34th cycle
        cnt0 = bus.stall_cnt_o;
        @(negedge clk);
        drive(0, 1, 1, 0, 0);
        #1;
        chk("div.c0.stall", 32'(bus.stall_o), 32'(STALL_EX));
        done_at = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0);
            #1;
            if (bus.ex_mc_done === 1'b1) begin
                done_at = c;
                chk("div.done.stall", 32'(bus.stall_o), 32'(STALL_NONE));
                break;
            end
            if (bus.stall_o !== STALL_EX || bus.ex_mc_step !== 6'(c)) begin
                chk($sformatf("div.c%0d.step", c), 32'(bus.ex_mc_step), 32'(c));
                chk($sformatf("div.c%0d.stall", c), 32'(bus.stall_o), 32'(STALL_EX));
            end
        end
        chk("div.done_cycle", 32'(done_at), 32'd33);
        chk("div.cnt_delta", bus.stall_cnt_o - cnt0, 32'd33);

        // Flush at DIV step 5 with a load-use hazard: flush wins, op aborted
        @(negedge clk);
        drive(0, 1, 1, 0, 0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0);
        end
        #1;
        chk("fl.pre.step", 32'(bus.ex_mc_step), 32'd5);
        bus.flush_req   = 1'b1;
        bus.stallreq_id = 1'b1;
        #1;
        chk("fl.flush", 32'(bus.flush_o), 32'd1);
        chk("fl.stall", 32'(bus.stall_o), 32'(STALL_NONE));
        chk("fl.done",  32'(bus.ex_mc_done), 32'd0);
        // Fresh MULT request right after the flush cycle
        @(negedge clk);
        drive(0, 1, 0, 0, 0);
        #1;
        chk("fl.post.busy",  32'(bus.ex_mc_busy), 32'd0);
        chk("fl.post.step",  32'(bus.ex_mc_step), 32'd0);
        chk("fl.post.done",  32'(bus.ex_mc_done), 32'd0);
        chk("fl.post.stall", 32'(bus.stall_o), 32'(STALL_EX));
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0);
            #1;
            chk($sformatf("fl.mult.c%0d.step", c), 32'(bus.ex_mc_step), 32'(c));
            chk($sformatf("fl.mult.c%0d.done", c), 32'(bus.ex_mc_done), 32'd0);
        end
        @(negedge clk);
        #1;
        chk("fl.mult.done", 32'(bus.ex_mc_done), 32'd1);
        chk("fl.mult.stall", 32'(bus.stall_o), 32'(STALL_NONE));

        // Reset mid-BUSY at DIV step 10
        @(negedge clk);
        drive(0, 1, 1, 0, 0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0);
        end
        #1;
        chk("rst.pre.step", 32'(bus.ex_mc_step), 32'd10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst.in.stall", 32'(bus.stall_o), 32'(STALL_NONE));
        chk("rst.in.busy",  32'(bus.ex_mc_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.post.busy",  32'(bus.ex_mc_busy), 32'd0);
        chk("rst.post.step",  32'(bus.ex_mc_step), 32'd0);
        chk("rst.post.stall", 32'(bus.stall_o), 32'(STALL_NONE));
        chk("rst.post.cnt",   bus.stall_cnt_o, 32'd0);
        @(negedge clk);
        #1;
        chk("rst.post2.stall", 32'(bus.stall_o), 32'(STALL_NONE));
        chk("rst.post2.done",  32'(bus.ex_mc_done), 32'd0);

        // Saturation on the preset instance: FFFFFFFE -> FFFFFFFF and holds
        chk("sat.c0", bus2.stall_cnt_o, 32'hFFFF_FFFE);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus2.stallreq_id = 1'b1;
            #1;
            chk($sformatf("sat.stall%0d", c), 32'(bus2.stall_o), 32'(STALL_ID));
            chk($sformatf("sat.cnt%0d", c), bus2.stall_cnt_o,
                (c == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
        end
        @(negedge clk);
        bus2.stallreq_id = 1'b0;
        #1;
        chk("sat.hold", bus2.stall_cnt_o, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
